multicycle_control: RTL and testbench

- Sequencing control unit for the multicycle MIPS datapath.
- Tracks instruction phase: FETCH, DECODE, EXEC, MEM, WB, HALTED.
- Issues one-cycle datapath strobes and stalls on memory waitrequest.
- Owns a parametrised multiply/divide latency counter that interlocks HI/LO accesses. Static field decode (rd_select, alu_op, imdt_sel, …) stays combinational outside this block; this block gates the write and memory strobes.

---
 rtl/multicycle_control_if.sv | 55 +++++
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
//
// Bundles the signals between the multicycle sequencing control unit and the
// MIPS datapath / memory.
//
//   Datapath -> control : opcode, function_code, b_code (instruction fields
//                         from the IR), waitrequest (memory not ready),
//                         halt_req (halt condition sampled in DECODE).
//   Control -> datapath : state, active, memory strobes, register-file and
//                         HI/LO write strobes, multiply/divide start and busy.
//
// Memory handshake: an access is requested by holding mem_read or mem_write
// high. It completes on the first clock edge at which waitrequest is low.
// While waitrequest is high the strobes, mem_addr_sel and the state hold
// unchanged.
//
// Modports:
//   master : the control unit (drives strobes, observes instruction fields)
//   slave  : the datapath side (drives instruction fields, observes strobes)
// ---------------------------------------------------------------------------
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] function_code;
    logic [4:0] b_code;
    logic       waitrequest;
    logic       halt_req;

    logic [2:0] state;
    logic       active;
    logic       mem_read;
    logic       mem_write;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write_enable;
    logic       hi_wren;
    logic       lo_wren;
    logic       muldiv_start;
    logic       muldiv_busy;

    modport master (
        input  opcode, function_code, b_code, waitrequest, halt_req,
        output state, active, mem_read, mem_write, mem_addr_sel, ir_write,
               pc_write, reg_write_enable, hi_wren, lo_wren, muldiv_start,
               muldiv_busy
    );

    modport slave (
        output opcode, function_code, b_code, waitrequest, halt_req,
        input  state, active, mem_read, mem_write, mem_addr_sel, ir_write,
               pc_write, reg_write_enable, hi_wren, lo_wren, muldiv_start,
               muldiv_busy
    );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Sequencing control unit for the multicycle MIPS datapath. Walks each
// instruction through FETCH, DECODE, EXEC, MEM and WB (or HALTED). It issues
// one-cycle datapath strobes, stalls on memory waitrequest, and owns the
// multiply/divide latency counter that interlocks HI/LO accesses.
//
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset. While it is low every output
//              is forced to 0 combinationally.
//   bus      : multicycle_control_if.master. It carries the instruction
//              fields and waitrequest/halt_req in, and the state and strobes
//              out. The state output doubles as the FSM debug view.
//
// Parameters:
//   MULT_CYCLES : cycles from mult/multu issue to the HI/LO commit pulse
//   DIV_CYCLES  : cycles from div/divu issue to the HI/LO commit pulse
//   CNT_W       : latency counter width; must hold max(MULT/DIV_CYCLES)
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    multicycle_control_if.master   bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // ---------------- instruction class decode ----------------
    logic [5:0] op;
    logic [5:0] fn;
    logic       is_rtype;
    logic       is_load, is_store;
    logic       is_hilo_rd, is_hilo_wr, is_muldiv;
    logic       is_link, is_ctrl_only, writes_reg;

    assign op = bus.opcode;
    assign fn = bus.function_code;

    always_comb begin
        is_rtype   = (op == 6'd0);
        is_load    = (op >= 6'd32) && (op <= 6'd38);
        is_store   = (op == 6'd40) || (op == 6'd41) || (op == 6'd43);
        is_hilo_rd = is_rtype && ((fn == 6'd16) || (fn == 6'd18));
        is_hilo_wr = is_rtype && ((fn == 6'd17) || (fn == 6'd19));
        is_muldiv  = is_rtype && (fn >= 6'd24) && (fn <= 6'd27);
        // jal, jalr, bltzal/bgezal
        is_link    = (op == 6'd3)
                   || (is_rtype && (fn == 6'd9))
                   || ((op == 6'd1) && ((bus.b_code == 5'd16) || (bus.b_code == 5'd17)));
        // Branches/jumps that only update the PC, plus jr.
        is_ctrl_only = (((op == 6'd1) || (op == 6'd2) || ((op >= 6'd4) && (op <= 6'd7)))
                        && !is_link)
                     || (is_rtype && (fn == 6'd8));
        writes_reg = is_link
                   || ((op >= 6'd9) && (op <= 6'd15))
                   || is_load
                   || (is_rtype && !((fn == 6'd8) || (fn == 6'd17) || (fn == 6'd19)
                                     || ((fn >= 6'd24) && (fn <= 6'd27))));
    end

    // ---------------- latency counter status ----------------
    logic busy;
    logic commit;

    assign busy   = (cnt_q != '0);
    // The cycle the counter steps 1 -> 0 is the HI/LO result commit.
    assign commit = (cnt_q == CNT_W'(1));

    // ---------------- state and counter registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- next state and strobes ----------------
    logic mem_read_c, mem_write_c, mem_addr_sel_c, ir_write_c, pc_write_c;
    logic reg_we_c, hi_exec_c, lo_exec_c, start_c;

    always_comb begin
        state_d        = state_q;
        mem_read_c     = 1'b0;
        mem_write_c    = 1'b0;
        mem_addr_sel_c = 1'b0;
        ir_write_c     = 1'b0;
        pc_write_c     = 1'b0;
        reg_we_c       = 1'b0;
        hi_exec_c      = 1'b0;
        lo_exec_c      = 1'b0;
        start_c        = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read_c = 1'b1;
                if (!bus.waitrequest) begin
                    ir_write_c = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                if (bus.halt_req) begin
                    state_d = HALTED;
                end else if (!((is_hilo_rd || is_hilo_wr || is_muldiv) && busy)) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_muldiv) begin
                    start_c    = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = FETCH;
                end else if (is_hilo_wr) begin
                    hi_exec_c  = (fn == 6'd17);
                    lo_exec_c  = (fn == 6'd19);
                    pc_write_c = 1'b1;
                    state_d    = FETCH;
                end else if (is_ctrl_only) begin
                    pc_write_c = 1'b1;
                    state_d    = FETCH;
                end else if (is_load || is_store) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                mem_addr_sel_c = 1'b1;
                mem_read_c     = is_load;
                mem_write_c    = is_store;
                if (!bus.waitrequest) begin
                    if (is_load) begin
                        state_d = WB;
                    end else begin
                        pc_write_c = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            WB: begin
                reg_we_c   = writes_reg;
                pc_write_c = 1'b1;
                state_d    = FETCH;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // A new mult/div only issues when idle (DECODE interlock), so a load
    // never overlaps a running count. fn bit 1 separates div (26/27) from
    // mult (24/25).
    always_comb begin
        cnt_d = cnt_q;
        if (start_c) begin
            cnt_d = fn[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // ---------------- outputs, forced low while in reset ----------------
    assign bus.state            = reset_n ? state_q : FETCH;
    assign bus.active           = reset_n && (state_q != HALTED);
    assign bus.mem_read         = reset_n && mem_read_c;
    assign bus.mem_write        = reset_n && mem_write_c;
    assign bus.mem_addr_sel     = reset_n && mem_addr_sel_c;
    assign bus.ir_write         = reset_n && ir_write_c;
    assign bus.pc_write         = reset_n && pc_write_c;
    assign bus.reg_write_enable = reset_n && reg_we_c;
    assign bus.hi_wren          = reset_n && (hi_exec_c || commit);
    assign bus.lo_wren          = reset_n && (lo_exec_c || commit);
    assign bus.muldiv_start     = reset_n && start_c;
    assign bus.muldiv_busy      = reset_n && busy;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. Each step drives the instruction
// fields, samples state and the packed strobe vector on the falling edge,
// and compares them against hand-computed values.
// MULT_CYCLES is raised to 8 so that a multu is still counting when the
// following sw reaches MEM.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    multicycle_control_if bus_if ();

    multicycle_control #(
        .MULT_CYCLES (8),
        .DIV_CYCLES  (32),
        .CNT_W       (6)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    // Strobe vector bit weights:
    // {active, mem_read, mem_write, mem_addr_sel, ir_write, pc_write,
    //  reg_write_enable, hi_wren, lo_wren, muldiv_start, muldiv_busy}
    localparam logic [10:0] A   = 11'h400;
    localparam logic [10:0] RD  = 11'h200;
    localparam logic [10:0] WR  = 11'h100;
    localparam logic [10:0] AS  = 11'h080;
    localparam logic [10:0] IRW = 11'h040;
    localparam logic [10:0] PCW = 11'h020;
    localparam logic [10:0] RWE = 11'h010;
    localparam logic [10:0] HI  = 11'h008;
    localparam logic [10:0] LO  = 11'h004;
    localparam logic [10:0] ST  = 11'h002;
    localparam logic [10:0] BSY = 11'h001;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] strobes();
        return {bus_if.active, bus_if.mem_read, bus_if.mem_write, bus_if.mem_addr_sel,
                bus_if.ir_write, bus_if.pc_write, bus_if.reg_write_enable,
                bus_if.hi_wren, bus_if.lo_wren, bus_if.muldiv_start,
                bus_if.muldiv_busy};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] b);
        bus_if.opcode        = op;
        bus_if.function_code = fn;
        bus_if.b_code        = b;
    endtask

    // Check the current cycle on the falling edge, then advance past the
    // next rising edge so the caller can drive the following cycle.
    task automatic step(input string tag, input logic [2:0] exp_state, input logic [10:0] exp_strb);
        @(negedge clk);
        check_eq({tag, "/state"}, 32'(bus_if.state), 32'(exp_state));
        check_eq({tag, "/strobes"}, 32'(strobes()), 32'(exp_strb));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n            = 1'b0;
        bus_if.waitrequest = 1'b0;
        bus_if.halt_req    = 1'b0;
        set_instr(6'd0, 6'd0, 5'd0);

        // ---- reset state ----
        #1;
        check_eq("reset/state", 32'(bus_if.state), 32'(S_FETCH));
        check_eq("reset/strobes", 32'(strobes()), 32'(11'h000));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // ---- addu ----
        set_instr(6'd0, 6'd33, 5'd0);
        step("addu_f", S_FETCH,  A | RD | IRW);
        step("addu_d", S_DECODE, A);
        step("addu_e", S_EXEC,   A);
        step("addu_w", S_WB,     A | PCW | RWE);

        // ---- lw with three wait cycles in MEM ----
        set_instr(6'd35, 6'd0, 5'd0);
        step("lw_f", S_FETCH,  A | RD | IRW);
        step("lw_d", S_DECODE, A);
        step("lw_e", S_EXEC,   A);
        bus_if.waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) step("lw_mwait", S_MEM, A | RD | AS);
        bus_if.waitrequest = 1'b0;
        step("lw_m", S_MEM, A | RD | AS);
        step("lw_w", S_WB,  A | PCW | RWE);

        // ---- sw ----
        set_instr(6'd43, 6'd0, 5'd0);
        step("sw_f", S_FETCH,  A | RD | IRW);
        step("sw_d", S_DECODE, A);
        step("sw_e", S_EXEC,   A);
        step("sw_m", S_MEM,    A | WR | AS | PCW);

        // ---- div followed immediately by mflo ----
        set_instr(6'd0, 6'd26, 5'd0);
        step("div_f", S_FETCH,  A | RD | IRW);
        step("div_d", S_DECODE, A);
        step("div_e", S_EXEC,   A | PCW | ST);
        set_instr(6'd0, 6'd18, 5'd0);
        step("mflo_f", S_FETCH, A | RD | IRW | BSY);
        for (int k = 2; k <= 31; k++) step("mflo_stall", S_DECODE, A | BSY);
        step("mflo_commit", S_DECODE, A | HI | LO | BSY);
        step("mflo_d",      S_DECODE, A);
        step("mflo_e",      S_EXEC,   A);
        step("mflo_w",      S_WB,     A | PCW | RWE);

        // ---- jal, then halt ----
        set_instr(6'd3, 6'd0, 5'd0);
        step("jal_f", S_FETCH,  A | RD | IRW);
        step("jal_d", S_DECODE, A);
        step("jal_e", S_EXEC,   A);
        step("jal_w", S_WB,     A | PCW | RWE);
        set_instr(6'd0, 6'd33, 5'd0);
        bus_if.halt_req = 1'b1;
        step("halt_f", S_FETCH,  A | RD | IRW);
        step("halt_d", S_DECODE, A);
        bus_if.halt_req = 1'b0;
        for (int i = 0; i < 100; i++) step("halted", S_HALTED, 11'h000);

        // ---- leave HALTED via reset ----
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;

        // ---- multu, then sw interrupted by reset in MEM ----
        set_instr(6'd0, 6'd25, 5'd0);
        step("multu_f", S_FETCH,  A | RD | IRW);
        step("multu_d", S_DECODE, A);
        step("multu_e", S_EXEC,   A | PCW | ST);
        set_instr(6'd43, 6'd0, 5'd0);
        step("sw2_f", S_FETCH,  A | RD | IRW | BSY);
        step("sw2_d", S_DECODE, A | BSY);
        step("sw2_e", S_EXEC,   A | BSY);
        bus_if.waitrequest = 1'b1;
        @(negedge clk);
        check_eq("sw2_m/state", 32'(bus_if.state), 32'(S_MEM));
        check_eq("sw2_m/strobes", 32'(strobes()), 32'(A | WR | AS | BSY));
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("midrst/state", 32'(bus_if.state), 32'(S_FETCH));
        check_eq("midrst/strobes", 32'(strobes()), 32'(11'h000));
        #1;
        reset_n = 1'b1;
        #1;
        check_eq("release/state", 32'(bus_if.state), 32'(S_FETCH));
        check_eq("release/strobes", 32'(strobes()), 32'(A | RD));
        @(posedge clk);
        #1;
        // Counter must stay cleared: no busy and no commit pulse afterwards.
        for (int i = 0; i < 8; i++) step("post_rst", S_FETCH, A | RD);
        bus_if.waitrequest = 1'b0;
        step("post_rst_f", S_FETCH, A | RD | IRW);

        // ---- final report ----
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
